// File: rtl/md_sched_if.sv
// Multiply/divide scheduler bus: E-stage issue, D-stage use hint, busy/stall and HI/LO.
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, md_use_D,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, md_use_D,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide resource controller beside the E-stage ALU. Owns HI/LO, computes the
// full result at accept time, then holds it pending for a fixed busy window before commit.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Multiply: low 64 bits of sign- or zero-extended operands.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{32{bus.src_a[31]}}, bus.src_a};
  assign b_sx   = {{32{bus.src_b[31]}}, bus.src_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};

  // Divide on magnitudes, then fix signs; this makes 0x80000000 / -1 fall out naturally.
  logic        signed_op, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.src_a[31];
  assign b_neg     = signed_op & bus.src_b[31];
  assign a_mag     = a_neg ? (~bus.src_a + 32'd1) : bus.src_a;
  assign b_mag     = b_neg ? (~bus.src_b + 32'd1) : bus.src_b;
  assign b_zero    = (bus.src_b == 32'd0);
  assign q_mag     = a_mag / b_mag;
  assign r_mag     = a_mag % b_mag;
  assign quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem       = a_neg ? (~r_mag + 32'd1) : r_mag;

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ph_q    <= 32'd0;
      pl_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Accept ops when idle, count down while busy, commit pending result on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              {ph_d, pl_d} = bus.op[0] ? prod_u : prod_s;
              cnt_d        = MultLoad;
              state_d      = StBusy;
            end
            3'd2, 3'd3: begin
              // Divide by zero leaves HI/LO as they are but still occupies the unit.
              if (b_zero) begin
                ph_d = hi_q;
                pl_d = lo_q;
              end else begin
                ph_d = rem;
                pl_d = quot;
              end
              cnt_d   = DivLoad;
              state_d = StBusy;
            end
            3'd4:    hi_d = bus.src_a;
            3'd5:    lo_d = bus.src_a;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          hi_d    = ph_q;
          lo_d    = pl_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy      = (state_q == StBusy);
  assign bus.stall_req = bus.md_use_D & (bus.busy | (bus.start & ~bus.op[2]));
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
